// File: rtl/gp_eval_pkg.sv
// gp_eval_pkg: shared types and constants for the GP fitness-evaluation stage.
//   scorer_state_t : truth_table_scorer FSM states
//   SETTLE_W       : width of the settle counter (SETTLE_CYC range 1..15)
package gp_eval_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } scorer_state_t;

   localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/truth_table_scorer_if.sv
// truth_table_scorer_if: control/result bundle of the truth-table scorer.
//   start          : request an evaluation run (master -> slave)
//   busy, done     : run status, done is a one-cycle pulse (slave -> master)
//   score          : number of matching vectors
//   mismatch_mask  : bit i set if vector i mismatched
//   all_pass       : every vector matched
// Modports: master = requester (GP loop / bench), slave = scorer.
interface truth_table_scorer_if #(
   parameter int unsigned N_IN = 4
);

   logic                 start;
   logic                 busy;
   logic                 done;
   logic [N_IN:0]        score;
   logic [2**N_IN-1:0]   mismatch_mask;
   logic                 all_pass;

   modport master (
      output start,
      input  busy, done, score, mismatch_mask, all_pass
   );

   modport slave (
      input  start,
      output busy, done, score, mismatch_mask, all_pass
   );

endinterface

// File: rtl/settle_counter.sv
// settle_counter: counts cycles spent holding a vector before it is sampled.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : increment by one
//   tc         : terminal count, high while count == SETTLE_CYC-1
module settle_counter
   import gp_eval_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE_CYC - 1);

   logic [SETTLE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/truth_table_scorer.sv
// truth_table_scorer: drives every input vector 0..2^N_IN-1 into a candidate cell, samples its
// output after SETTLE_CYC cycles and scores it against the TARGET truth table.
//   clk, rst_n : clock, asynchronous active-low reset
//   ctl        : slave side of truth_table_scorer_if (start/busy/done/score/mask/all_pass)
//   vec_out    : vector to the candidate, MSB = first candidate input
//   dut_out    : candidate output, only looked at in SAMPLE
module truth_table_scorer
   import gp_eval_pkg::*;
#(
   parameter int unsigned             N_IN       = 4,
   parameter logic [2**N_IN-1:0]      TARGET     = 16'hE000,
   parameter int unsigned             SETTLE_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   truth_table_scorer_if.slave  ctl,
   output logic [N_IN-1:0]      vec_out,
   input  logic                 dut_out
);

   localparam int unsigned        NVEC     = 2**N_IN;
   localparam logic [N_IN-1:0]    LAST_IDX = N_IN'(NVEC - 1);
   localparam logic [N_IN:0]      FULL     = (N_IN + 1)'(NVEC);

   scorer_state_t     state;
   logic [N_IN-1:0]   idx;
   logic [N_IN:0]     score;
   logic [N_IN:0]     score_inc;
   logic [NVEC-1:0]   mask;
   logic              busy;
   logic              done;
   logic              all_pass;
   logic              hit;
   logic              tc;

   settle_counter #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != DRIVE),
      .en    (state == DRIVE),
      .tc    (tc)
   );

   assign hit       = (dut_out == TARGET[idx]);
   assign score_inc = score + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         vec_out  <= '0;
         score    <= '0;
         mask     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         all_pass <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ctl.start) begin
                  idx      <= '0;
                  vec_out  <= '0;
                  score    <= '0;
                  mask     <= '0;
                  all_pass <= 1'b0;
                  busy     <= 1'b1;
                  state    <= DRIVE;
               end
            end
            DRIVE: begin
               if (tc) state <= SAMPLE;
            end
            SAMPLE: begin
               if (hit) score <= score_inc;
               else     mask[idx] <= 1'b1;
               // Explicit last-vector compare: idx never wraps.
               if (idx == LAST_IDX) begin
                  // all_pass is resolved here so it is already valid alongside done.
                  all_pass <= hit && (score_inc == FULL);
                  done     <= 1'b1;
                  vec_out  <= '0;
                  state    <= DONE;
               end else begin
                  idx     <= idx + 1'b1;
                  vec_out <= idx + 1'b1;
                  state   <= DRIVE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ctl.busy          = busy;
   assign ctl.done          = done;
   assign ctl.score         = score;
   assign ctl.mismatch_mask = mask;
   assign ctl.all_pass      = all_pass;

endmodule
